trap_sequencer: RTL and testbench

- Multi-cycle controller behind the writeback stage.
- Sequences machine-mode trap entry (mepc, mcause, mtval, mstatus) and MRET exit through the core's single CSR write port.
- Arbitrates that port between normal CSR-instruction commits and its own trap writes.
- Drives pipeline stall and flush, and the PC redirect to the fetch stage.

---
 rtl/core_pkg.sv | 26 ++
 rtl/trap_sequencer_if.sv | 45 ++++
 rtl/trap_sequencer_target_gen.sv | 34 +++
 rtl/trap_sequencer.sv | 153 +++++++++++++++
 tb/tb_trap_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared constants for the trap sequencer: CSR addresses, mstatus bit
// positions and the sequencer FSM state encoding.
package core_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_EPC,
    S_W_CAUSE,
    S_W_TVAL,
    S_W_STATUS,
    S_REDIRECT,
    S_R_STATUS
  } seq_state_e;

endpackage

// File: rtl/trap_sequencer_if.sv
// Writeback/trap/CSR-port bundle between the core and the trap sequencer.
// master = sequencer side, slave = core side.
interface trap_sequencer_if #(
  parameter int unsigned XLEN = 64
);
  logic            WB_V;
  logic            WB_ST_CSR;
  logic [11:0]     WB_CSR_ADDR;
  logic [XLEN-1:0] WB_CSR_DATA;
  logic [XLEN-1:0] WB_PC;
  logic            TRAP_REQ;
  logic [XLEN-1:0] TRAP_CAUSE;
  logic [XLEN-1:0] TRAP_TVAL;
  logic            MRET_REQ;
  logic            PRIVILEGE;
  logic [XLEN-1:0] MTVEC_IN;
  logic [XLEN-1:0] MEPC_IN;
  logic [XLEN-1:0] MSTATUS_IN;
  logic            CSR_WE;
  logic [11:0]     CSR_ADDR;
  logic [XLEN-1:0] CSR_WDATA;
  logic            SEQ_STALL;
  logic            SEQ_FLUSH;
  logic            REDIR_V;
  logic [XLEN-1:0] REDIR_PC;
  logic            PRIV_NEXT;
  logic            SEQ_BUSY;

  modport master (
    input  WB_V, WB_ST_CSR, WB_CSR_ADDR, WB_CSR_DATA, WB_PC,
    input  TRAP_REQ, TRAP_CAUSE, TRAP_TVAL, MRET_REQ, PRIVILEGE,
    input  MTVEC_IN, MEPC_IN, MSTATUS_IN,
    output CSR_WE, CSR_ADDR, CSR_WDATA, SEQ_STALL, SEQ_FLUSH,
    output REDIR_V, REDIR_PC, PRIV_NEXT, SEQ_BUSY
  );

  modport slave (
    output WB_V, WB_ST_CSR, WB_CSR_ADDR, WB_CSR_DATA, WB_PC,
    output TRAP_REQ, TRAP_CAUSE, TRAP_TVAL, MRET_REQ, PRIVILEGE,
    output MTVEC_IN, MEPC_IN, MSTATUS_IN,
    input  CSR_WE, CSR_ADDR, CSR_WDATA, SEQ_STALL, SEQ_FLUSH,
    input  REDIR_V, REDIR_PC, PRIV_NEXT, SEQ_BUSY
  );

endinterface

// File: rtl/trap_sequencer_target_gen.sv
// Redirect target for trap entry (mtvec base, optionally vectored) or MRET (mepc).
// Vectored interrupt dispatch is enabled by defining TRAP_VECTORED_EN.
module trap_target_gen #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] cause,
  input  logic            is_mret,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_pc;
  logic            unused_inputs;

  assign base = {mtvec[XLEN-1:MTVEC_ALIGN], {MTVEC_ALIGN{1'b0}}};

`ifdef TRAP_VECTORED_EN
  logic            vectored;
  logic [XLEN-1:0] offset;

  assign vectored = (mtvec[1:0] == 2'b01) && cause[XLEN-1];
  assign offset   = {{(XLEN-8){1'b0}}, cause[5:0], 2'b00};
  assign trap_pc  = vectored ? base + offset : base;
`else
  assign trap_pc  = base;
`endif

  assign unused_inputs = ^{cause, mtvec[MTVEC_ALIGN-1:0]};
  assign target        = is_mret ? mepc : trap_pc;

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry / MRET sequencer sharing the single CSR write port with writeback.
// Optional vectored dispatch: define TRAP_VECTORED_EN.
module trap_sequencer
  import core_pkg::*;
#(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned MTVEC_ALIGN = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  trap_sequencer_if.master bus
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, cause_q, tval_q, mstatus_q, mtvec_q, mepc_q;
  logic            mret_q, priv_q, accept;
  logic [XLEN-1:0] status_trap, status_mret, target;
  logic            csr_we, stall, flush, redir_v;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            unused_pc_bits;

  trap_target_gen #(
    .XLEN        (XLEN),
    .MTVEC_ALIGN (MTVEC_ALIGN)
  ) u_target (
    .mtvec   (mtvec_q),
    .mepc    (mepc_q),
    .cause   (cause_q),
    .is_mret (mret_q),
    .target  (target)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mret_q    <= 1'b0;
      priv_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q      <= bus.WB_PC;
        cause_q   <= bus.TRAP_CAUSE;
        tval_q    <= bus.TRAP_TVAL;
        mstatus_q <= bus.MSTATUS_IN;
        mtvec_q   <= bus.MTVEC_IN;
        mepc_q    <= bus.MEPC_IN;
        mret_q    <= ~bus.TRAP_REQ;
      end
      if (state_q == S_R_STATUS)
        priv_q <= |mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      else if (state_q == S_REDIRECT && !mret_q)
        priv_q <= 1'b1;
    end
  end

  always_comb begin
    status_trap = mstatus_q;
    status_trap[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]  = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = bus.PRIVILEGE ? 2'b11 : 2'b00;
    status_mret = mstatus_q;
    status_mret[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE] = 1'b1;
    status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    redir_v   = 1'b0;
    case (state_q)
      S_IDLE: begin
        csr_we    = bus.WB_V & bus.WB_ST_CSR;
        csr_addr  = bus.WB_CSR_ADDR;
        csr_wdata = bus.WB_CSR_DATA;
        // The instruction that raised the trap (or the MRET) must not commit its CSR write.
        if (bus.TRAP_REQ || bus.MRET_REQ) begin
          accept  = 1'b1;
          csr_we  = 1'b0;
          stall   = 1'b1;
          flush   = 1'b1;
          state_d = bus.TRAP_REQ ? S_W_EPC : S_R_STATUS;
        end
      end
      S_W_EPC: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MEPC;
        csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        stall     = 1'b1;
        state_d   = S_W_CAUSE;
      end
      S_W_CAUSE: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MCAUSE;
        csr_wdata = cause_q;
        stall     = 1'b1;
        state_d   = S_W_TVAL;
      end
      S_W_TVAL: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MTVAL;
        csr_wdata = tval_q;
        stall     = 1'b1;
        state_d   = S_W_STATUS;
      end
      S_W_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = status_trap;
        stall     = 1'b1;
        state_d   = S_REDIRECT;
      end
      S_R_STATUS: begin
        csr_we    = 1'b1;
        csr_addr  = CSR_MSTATUS;
        csr_wdata = status_mret;
        stall     = 1'b1;
        state_d   = S_REDIRECT;
      end
      S_REDIRECT: begin
        stall   = 1'b1;
        redir_v = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign unused_pc_bits = ^pc_q[1:0];

  assign bus.CSR_WE    = csr_we;
  assign bus.CSR_ADDR  = csr_addr;
  assign bus.CSR_WDATA = csr_wdata;
  assign bus.SEQ_STALL = stall;
  assign bus.SEQ_FLUSH = flush;
  assign bus.REDIR_V   = redir_v;
  assign bus.REDIR_PC  = redir_v ? target : '0;
  assign bus.PRIV_NEXT = priv_q;
  assign bus.SEQ_BUSY  = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: per-cycle expected outputs are queued
// with the stimulus and popped/compared at the falling edge.
module tb_trap_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trap_sequencer_if #(.XLEN(64)) bus ();

  trap_sequencer #(
    .XLEN        (64),
    .MTVEC_ALIGN (2)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        stall;
    logic        flush;
    logic        redir_v;
    logic [63:0] redir_pc;
    logic        priv;
    logic        busy;
  } obs_t;

  obs_t exp_q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic exp_priv = 1'b1;

  function automatic obs_t mk(logic we, logic [11:0] a, logic [63:0] d, logic st, logic fl,
                              logic rv, logic [63:0] rpc, logic pv, logic bz);
    obs_t r;
    r.we = we; r.addr = a; r.wdata = d; r.stall = st; r.flush = fl;
    r.redir_v = rv; r.redir_pc = rpc; r.priv = pv; r.busy = bz;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r.we = bus.CSR_WE; r.addr = bus.CSR_ADDR; r.wdata = bus.CSR_WDATA;
    r.stall = bus.SEQ_STALL; r.flush = bus.SEQ_FLUSH; r.redir_v = bus.REDIR_V;
    r.redir_pc = bus.REDIR_PC; r.priv = bus.PRIV_NEXT; r.busy = bus.SEQ_BUSY;
    return r;
  endfunction

  task automatic idle_inputs();
    bus.WB_V = 1'b0; bus.WB_ST_CSR = 1'b0; bus.WB_CSR_ADDR = '0; bus.WB_CSR_DATA = '0;
    bus.WB_PC = '0; bus.TRAP_REQ = 1'b0; bus.TRAP_CAUSE = '0; bus.TRAP_TVAL = '0;
    bus.MRET_REQ = 1'b0; bus.MTVEC_IN = '0; bus.MEPC_IN = '0; bus.MSTATUS_IN = '0;
  endtask

  // Latched values must be used after acceptance, so the live inputs are scrambled.
  task automatic garbage_inputs();
    bus.WB_PC = '1; bus.TRAP_CAUSE = 64'h5A5A; bus.TRAP_TVAL = 64'hDEAD;
    bus.MTVEC_IN = 64'hFFFF_0F0C; bus.MEPC_IN = 64'hBAD0; bus.MSTATUS_IN = '1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    idle_inputs();
    bus.PRIVILEGE = 1'b1;
    rst = 1'b1;
    exp_q.push_back(mk(0, '0, '0, 0, 0, 0, '0, 1, 0));
    exp_q.push_back(mk(0, '0, '0, 0, 0, 0, '0, 1, 0));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst = 1'b0;
      @(negedge clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL reset_c%0d got=%h exp=%h", c, o, e); end
    end
    exp_priv = 1'b1;
  endtask

  task automatic test_csr_passthrough();
    obs_t o, e;
    exp_q.push_back(mk(1, 12'h340, 64'hAB, 0, 0, 0, '0, exp_priv, 0));
    exp_q.push_back(mk(0, 12'h340, 64'hAB, 0, 0, 0, '0, exp_priv, 0));
    exp_q.push_back(mk(0, 12'h000, 64'h0, 0, 0, 0, '0, exp_priv, 0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (c < 2) begin
        bus.WB_V = (c == 0); bus.WB_ST_CSR = 1'b1;
        bus.WB_CSR_ADDR = 12'h340; bus.WB_CSR_DATA = 64'hAB;
      end
      @(negedge clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL passthru_c%0d got=%h exp=%h", c, o, e); end
    end
  endtask

  task automatic test_trap(string name, logic [63:0] pc, logic [63:0] cause, logic [63:0] tval,
                           logic [63:0] mstatus, logic priv, logic [63:0] mtvec,
                           logic [63:0] exp_status, logic [63:0] exp_redir, logic hold);
    obs_t o, e;
    logic [63:0] epc;
    epc = {pc[63:2], 2'b00};
    exp_q.push_back(mk(0, hold ? 12'h7C0 : 12'h0, hold ? 64'h5555 : 64'h0, 1, 1, 0, '0, exp_priv, 0));
    exp_q.push_back(mk(1, 12'h341, epc, 1, 0, 0, '0, exp_priv, 1));
    exp_q.push_back(mk(1, 12'h342, cause, 1, 0, 0, '0, exp_priv, 1));
    exp_q.push_back(mk(1, 12'h343, tval, 1, 0, 0, '0, exp_priv, 1));
    exp_q.push_back(mk(1, 12'h300, exp_status, 1, 0, 0, '0, exp_priv, 1));
    exp_q.push_back(mk(0, 12'h000, '0, 1, 0, 1, exp_redir, exp_priv, 1));
    exp_q.push_back(mk(0, 12'h000, '0, 0, 0, 0, '0, 1, 0));
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        idle_inputs();
        bus.TRAP_REQ = 1'b1; bus.WB_PC = pc; bus.TRAP_CAUSE = cause; bus.TRAP_TVAL = tval;
        bus.MSTATUS_IN = mstatus; bus.PRIVILEGE = priv; bus.MTVEC_IN = mtvec;
        bus.MEPC_IN = 64'h1234_5678;
        if (hold) begin
          bus.MRET_REQ = 1'b1; bus.WB_V = 1'b1; bus.WB_ST_CSR = 1'b1;
          bus.WB_CSR_ADDR = 12'h7C0; bus.WB_CSR_DATA = 64'h5555;
        end
      end else if (c < 6) begin
        garbage_inputs();
        if (!hold) bus.TRAP_REQ = 1'b0;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL %s_c%0d got=%h exp=%h", name, c, o, e); end
    end
    exp_priv = 1'b1;
  endtask

  task automatic test_mret(string name, logic [63:0] mstatus, logic [63:0] mepc,
                           logic [63:0] exp_status, logic new_priv);
    obs_t o, e;
    exp_q.push_back(mk(0, 12'h000, '0, 1, 1, 0, '0, exp_priv, 0));
    exp_q.push_back(mk(1, 12'h300, exp_status, 1, 0, 0, '0, exp_priv, 1));
    exp_q.push_back(mk(0, 12'h000, '0, 1, 0, 1, mepc, new_priv, 1));
    exp_q.push_back(mk(0, 12'h000, '0, 0, 0, 0, '0, new_priv, 0));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        idle_inputs();
        bus.MRET_REQ = 1'b1; bus.MSTATUS_IN = mstatus; bus.MEPC_IN = mepc;
        bus.MTVEC_IN = 64'h8000_0000; bus.WB_PC = 64'h8000_0900;
      end else if (c < 3) begin
        garbage_inputs();
        bus.MRET_REQ = 1'b0;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL %s_c%0d got=%h exp=%h", name, c, o, e); end
    end
    exp_priv = new_priv;
  endtask

  task automatic test_reset_midseq();
    obs_t o, e;
    exp_q.push_back(mk(0, 12'h000, '0, 1, 1, 0, '0, exp_priv, 0));
    exp_q.push_back(mk(1, 12'h341, 64'h8000_0300, 1, 0, 0, '0, exp_priv, 1));
    exp_q.push_back(mk(1, 12'h342, 64'h5, 1, 0, 0, '0, exp_priv, 1));
    for (int c = 3; c < 7; c++) exp_q.push_back(mk(0, 12'h000, '0, 0, 0, 0, '0, 1, 0));
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        idle_inputs();
        bus.TRAP_REQ = 1'b1; bus.WB_PC = 64'h8000_0300; bus.TRAP_CAUSE = 64'h5;
        bus.TRAP_TVAL = 64'h77; bus.MSTATUS_IN = 64'h8; bus.MTVEC_IN = 64'h8000_0000;
      end else begin
        idle_inputs();
      end
      if (c == 2) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      @(negedge clk);
      o = sample(); e = exp_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL rst_mid_c%0d got=%h exp=%h", c, o, e); end
    end
    exp_priv = 1'b1;
  endtask

  task automatic test_vectored();
    logic [63:0] irq_target;
`ifdef TRAP_VECTORED_EN
    irq_target = 64'h8000_001C;
`else
    irq_target = 64'h8000_0000;
`endif
    test_trap("vec_irq", 64'h8000_0400, 64'h8000_0000_0000_0007, 64'h0, 64'h8, 1'b1,
              64'h8000_0001, 64'h1880, irq_target, 1'b0);
    test_trap("vec_exc", 64'h8000_0404, 64'h7, 64'h10, 64'h0, 1'b1,
              64'h8000_0001, 64'h1800, 64'h8000_0000, 1'b0);
    test_trap("mode3_irq", 64'h8000_0408, 64'h8000_0000_0000_0003, 64'h0, 64'h0, 1'b1,
              64'h8000_0003, 64'h1800, 64'h8000_0000, 1'b0);
  endtask

  initial begin
    idle_inputs();
    bus.PRIVILEGE = 1'b1;
    test_reset();
    test_csr_passthrough();
    bus.PRIVILEGE = 1'b0;
    test_trap("illegal", 64'h8000_0104, 64'h2, 64'h0000_FFFF, 64'h8, 1'b0,
              64'h8000_0000, 64'h80, 64'h8000_0000, 1'b0);
    test_trap("simul", 64'h8000_0206, 64'hB, 64'h0, 64'h0, 1'b1,
              64'h8000_0100, 64'h1800, 64'h8000_0100, 1'b1);
    test_mret("mret_m", 64'h1880, 64'h8000_0200, 64'h88, 1'b1);
    test_mret("mret_u", 64'h2080, 64'h8000_0500, 64'h2088, 1'b0);
    test_trap("trap_u", 64'h8000_0504, 64'h8, 64'h0, 64'h2088, 1'b0,
              64'h8000_0040, 64'h2080, 64'h8000_0040, 1'b0);
    test_reset_midseq();
    test_vectored();
    test_csr_passthrough();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
